// File: rtl/cacheline_adaptor_pkg.sv
// Shared sizing constants and FSM state type for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

    localparam int unsigned S_LINE  = 256;
    localparam int unsigned S_BURST = 64;
    localparam int unsigned BEATS   = S_LINE / S_BURST;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single cache-line read/write-back requests into four-beat memory bursts
// and reassembles read beats into a full line.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned s_line  = S_LINE,
    parameter int unsigned s_burst = S_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [s_line-1:0]    line_i,
    output logic [s_line-1:0]    line_o,
    output logic                 resp_o,
    output logic [31:0]          address_o,
    output logic                 read_o,
    output logic                 write_o,
    output logic [s_burst-1:0]   burst_o,
    input  logic [s_burst-1:0]   burst_i,
    input  logic                 resp_i
);

    localparam int unsigned NBEATS = s_line / s_burst;
    localparam int unsigned CW     = $clog2(NBEATS);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);
    localparam logic [31:0] OFFS_MASK = 32'(s_line / 8 - 1);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [s_line-1:0]    r_line;
    logic [s_line-1:0]    r_line_o;
    logic                 r_resp;
    logic [31:0]          r_addr;
    logic                 r_read;
    logic                 r_write;
    logic [s_burst-1:0]   r_burst;

    logic [31:0]          w_addr_aligned;
    logic [s_line-1:0]    w_asm;

    assign w_addr_aligned = address_i & ~OFFS_MASK;
    // Read beats enter at the top and shift down, so beat 0 ends up in the low slice.
    assign w_asm          = {burst_i, r_line[s_line-1:s_burst]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_line   <= '0;
            r_line_o <= '0;
            r_resp   <= 1'b0;
            r_addr   <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_burst  <= '0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (read_i || write_i) begin
                        r_addr <= w_addr_aligned;
                        r_line <= line_i;
                        r_cnt  <= '0;
                        if (read_i) begin
                            r_state <= READ;
                            r_read  <= 1'b1;
                        end else begin
                            r_state <= WRITE;
                            r_write <= 1'b1;
                            r_burst <= line_i[s_burst-1:0];
                        end
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line <= w_asm;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_line_o <= w_asm;
                            r_read   <= 1'b0;
                            r_resp   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_line <= r_line >> s_burst;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_burst <= '0;
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_burst <= r_line[2*s_burst-1:s_burst];
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_line_o;
    assign resp_o    = r_resp;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign burst_o   = r_burst;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed spec scenarios plus randomized transactions.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int unsigned  n_checks;
    int unsigned  n_fail;
    logic [255:0] exp_line_o;

    cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // One full cache transaction. gaps[k] = idle cycles inserted before beat k.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rline,
                          input logic [3:0][3:0] gaps, input bit wiggle);
        logic        is_rd;
        logic [31:0] exp_addr;
        is_rd    = rd;
        exp_addr = {addr[31:5], 5'b0};
        read_i = rd; write_i = wr; address_i = addr; line_i = wline; resp_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (read_o !== is_rd || write_o !== !is_rd || address_o !== exp_addr || resp_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start: read_o=%b write_o=%b address_o=%h resp_o=%b, required %b %b %h 0",
                     read_o, write_o, address_o, resp_o, is_rd, !is_rd, exp_addr);
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(gaps[k]); g++) begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
                if (wiggle) begin address_i = $urandom; line_i = rand_line(); end
                @(posedge clk); #1;
                n_checks++;
                if (read_o !== is_rd || write_o !== !is_rd || address_o !== exp_addr || resp_o !== 1'b0 ||
                    (!is_rd && burst_o !== wline[64*k +: 64])) begin
                    n_fail++;
                    $display("FAIL gap beat%0d: read_o=%b write_o=%b address_o=%h resp_o=%b burst_o=%h, required %b %b %h 0 %h",
                             k, read_o, write_o, address_o, resp_o, burst_o, is_rd, !is_rd, exp_addr,
                             wline[64*k +: 64]);
                end
            end
            resp_i  = 1'b1;
            burst_i = rline[64*k +: 64];
            if (!is_rd) begin
                n_checks++;
                if (burst_o !== wline[64*k +: 64]) begin
                    n_fail++;
                    $display("FAIL write beat%0d: burst_o=%h, required %h", k, burst_o, wline[64*k +: 64]);
                end
            end
            @(posedge clk); #1;
            resp_i = 1'b0;
            if (k < 3) begin
                n_checks++;
                if (read_o !== is_rd || write_o !== !is_rd || resp_o !== 1'b0 || address_o !== exp_addr) begin
                    n_fail++;
                    $display("FAIL mid beat%0d: read_o=%b write_o=%b resp_o=%b address_o=%h, required %b %b 0 %h",
                             k, read_o, write_o, resp_o, address_o, is_rd, !is_rd, exp_addr);
                end
            end
        end
        if (is_rd) exp_line_o = rline;
        n_checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== exp_line_o) begin
            n_fail++;
            $display("FAIL done: resp_o=%b read_o=%b write_o=%b line_o=%h, required 1 0 0 %h",
                     resp_o, read_o, write_o, line_o, exp_line_o);
        end
        read_i = 1'b0; write_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== exp_line_o) begin
            n_fail++;
            $display("FAIL after: resp_o=%b read_o=%b write_o=%b line_o=%h, required 0 0 0 %h",
                     resp_o, read_o, write_o, line_o, exp_line_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        exp_line_o = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || address_o !== '0 ||
            burst_o !== '0 || line_o !== '0) begin
            n_fail++;
            $display("FAIL reset: resp=%b rd=%b wr=%b addr=%h burst=%h line=%h, required all zero",
                     resp_o, read_o, write_o, address_o, burst_o, line_o);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || address_o !== '0) begin
            n_fail++;
            $display("FAIL reset_release: resp=%b rd=%b wr=%b addr=%h, required all zero",
                     resp_o, read_o, write_o, address_o);
        end
    endtask

    task automatic test_read();
        do_txn(1'b1, 1'b0, 32'h0000_1234, '0,
               {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, '0, 1'b0);
    endtask

    task automatic test_write();
        do_txn(1'b0, 1'b1, 32'hABCD_EF7F,
               {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000},
               rand_line(), '0, 1'b0);
    endtask

    task automatic test_gapped_read();
        do_txn(1'b1, 1'b0, 32'h8000_0041, '0, rand_line(), {4'd1, 4'd0, 4'd2, 4'd0}, 1'b0);
    endtask

    task automatic test_both_high();
        do_txn(1'b1, 1'b1, 32'h1234_5678, rand_line(), rand_line(), {4'd0, 4'd1, 4'd0, 4'd2}, 1'b0);
    endtask

    task automatic test_reset_midburst();
        read_i = 1'b1; address_i = 32'h0000_0FFF; resp_i = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        exp_line_o = '0;
        n_checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || address_o !== '0 ||
            burst_o !== '0 || line_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset: resp=%b rd=%b wr=%b addr=%h burst=%h line=%h, required all zero",
                     resp_o, read_o, write_o, address_o, burst_o, line_o);
        end
        read_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_resp: resp_o=%b, required 0", resp_o);
            end
        end
        @(negedge clk); rst = 1'b1;
        do_txn(1'b1, 1'b0, 32'h0000_0FFF, '0, rand_line(), {4'd0, 4'd0, 4'd1, 4'd0}, 1'b0);
    endtask

    task automatic test_spurious_resp();
        for (int c = 0; c < 3; c++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
            n_checks++;
            if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== exp_line_o) begin
                n_fail++;
                $display("FAIL spurious: resp=%b rd=%b wr=%b line=%h, required 0 0 0 %h",
                         resp_o, read_o, write_o, line_o, exp_line_o);
            end
        end
        resp_i = 1'b0;
        do_txn(1'b1, 1'b0, 32'h0000_2020, '0, rand_line(), '0, 1'b0);
    endtask

    task automatic test_random();
        logic             rd, wr;
        logic [3:0][3:0]  gaps;
        for (int t = 0; t < 16; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) wr = 1'b1;
            for (int k = 0; k < 4; k++) gaps[k] = 4'($urandom_range(0, 3));
            do_txn(rd, wr, $urandom, rand_line(), rand_line(), gaps, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        do_txn(1'b0, 1'b1, 32'h0000_00E0, rand_line(), rand_line(), '0, 1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_00E0, '0, rand_line(), '0, 1'b0);
        do_txn(1'b1, 1'b0, 32'hFFFF_FFFF, '0, rand_line(), '0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read();
        test_write();
        test_gapped_read();
        test_both_high();
        test_reset_midburst();
        test_spurious_resp();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter s_line, default 256: cache line width in bits.
REQ-002 Parameter s_burst, default 64: memory burst beat width in bits; s_line/s_burst = 4 beats.
REQ-003 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 address_i  in  32  cache-side line address (from the cache datapath pmem address).
REQ-007 read_i  in  1  cache line read request, held until resp_o.
REQ-008 write_i  in  1  cache line write-back request, held until resp_o.
REQ-009 line_i  in  256  write-back line data.
REQ-010 line_o  out  256  assembled read line.
REQ-011 resp_o  out  1  one-cycle completion pulse to cache.
REQ-012 address_o  out  32  memory-side address.
REQ-013 read_o  out  1  burst read request.
REQ-014 write_o  out  1  burst write request.
REQ-015 burst_o  out  64  outgoing write beat.
REQ-016 burst_i  in  64  incoming read beat.
REQ-017 resp_i  in  1  memory beat-valid/accept strobe.

Function
REQ-018 FSM states: IDLE, READ, WRITE, DONE; 2-bit beat counter cnt.
REQ-019 IDLE: on read_i=1 SHALL latch {address_i[31:5],5'b0} and line_i, clear cnt, go READ next edge; else on write_i=1 same latch, go WRITE.
REQ-020 read_i and write_i both high in IDLE SHALL be treated as a read.
REQ-021 READ: read_o=1, address_o=latched address; each cycle with resp_i=1 SHALL store burst_i into line bits [64*cnt+63:64*cnt] and increment cnt.
REQ-022 WRITE: write_o=1, burst_o=latched line bits [64*cnt+63:64*cnt]; each resp_i=1 SHALL increment cnt.
REQ-023 On the resp_i beat with cnt=3, SHALL go DONE next edge; read_o/write_o deassert in DONE.
REQ-024 DONE: resp_o=1 for exactly one cycle, line_o valid; SHALL return to IDLE next edge unconditionally.
REQ-025 Read latency: resp_o asserted exactly one cycle after the 4th resp_i beat; beats may be non-contiguous (gaps without resp_i stall cnt).
REQ-026 resp_i in IDLE or DONE SHALL be ignored; cnt wraps only via state exit, never mid-burst.
REQ-027 Request changes while READ/WRITE active SHALL be ignored until IDLE.
REQ-028 line_o SHALL hold its last assembled value between transactions.
REQ-029 address_o SHALL be 32-byte aligned (bits [4:0]=0) whenever read_o or write_o=1.

Reset
REQ-030 rst=0 at any time SHALL force IDLE, cnt=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0, latched line=0.
REQ-031 Reset mid-burst SHALL abandon the transfer with no resp_o; first request after rst release starts a fresh burst at beat 0.

Structure
REQ-032 Shared package SHALL hold s_line, s_burst, beat count constant (4) and the FSM state enum.
REQ-033 No sub-module; counter and line shift/assembly register are inline.

Verification
REQ-034 Read: address_i=0x0000_1234, read_i=1; memory returns beats 0x11..11,0x22..22,0x33..33,0x44..44 -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle after 4th beat.
REQ-035 Write: line_i={D3,D2,D1,D0}, write_i=1 -> write_o=1, burst_o=D0,D1,D2,D3 on successive resp_i, resp_o single pulse.
REQ-036 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> correct line assembly, resp_o only after 4th asserted beat.
REQ-037 read_i=write_i=1 simultaneously -> read_o=1, write_o=0 throughout.
REQ-038 rst=0 after 2 read beats -> all outputs 0 immediately (async), no resp_o; following read completes correctly with all 4 beats.
REQ-039 Spurious resp_i in IDLE -> no state change, cnt=0, no resp_o.
